// File: rtl/player_laser.sv
`default_nettype none
// ==========================================================================================
// player_laser : four-slot player laser pool with fire detect, cooldown, hit and top-exit
// clearing. Optional macro LASER_AUTOFIRE_EN makes a held fire key refire.      Rev 1.0
// ==========================================================================================
module player_laser #(
  parameter int LASER_SPEED = 6,
  parameter int COOLDOWN    = 8,
  parameter int LASER_W     = 4,
  parameter int LASER_H     = 12,
  parameter int SHIP_W      = 30
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       fire,
  input  logic [9:0] PSX,
  input  logic [9:0] PSY,
  input  logic       h1,
  input  logic       h2,
  input  logic       h3,
  input  logic       h4,
  output logic [9:0] PX1,
  output logic [9:0] PX2,
  output logic [9:0] PX3,
  output logic [9:0] PX4,
  output logic [9:0] PY1,
  output logic [9:0] PY2,
  output logic [9:0] PY3,
  output logic [9:0] PY4,
  output logic       PL1,
  output logic       PL2,
  output logic       PL3,
  output logic       PL4,
  output logic [9:0] laser_width,
  output logic [9:0] laser_height,
  output logic [7:0] shot_count
);

  localparam int              CD_W      = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE    = CD_W'(1);
  localparam logic [9:0]      SPEED_C   = 10'(LASER_SPEED);
  localparam logic [9:0]      LASER_W_C = 10'(LASER_W);
  localparam logic [9:0]      LASER_H_C = 10'(LASER_H);
  localparam logic [9:0]      X_OFF_C   = 10'((SHIP_W - LASER_W) / 2);

  logic [3:0]      pl_q, pl_d;
  logic [9:0]      px_q [4];
  logic [9:0]      px_d [4];
  logic [9:0]      py_q [4];
  logic [9:0]      py_d [4];
  logic [CD_W-1:0] cd_q, cd_d;
  logic            fire_q, fire_d;
  logic            armed_q, armed_d;
  logic [7:0]      shot_q, shot_d;

  logic [3:0]      hit;
  logic [3:0]      spawn_sel;
  logic            found;
  logic            req;
  logic            cd_ready;
  logic            spawn;

  assign hit = {h4, h3, h2, h1};

  always_comb begin
    fire_d  = fire;
    // The first edge after reset only samples fire, so a key held through reset is not a press.
    armed_d = 1'b1;
`ifdef LASER_AUTOFIRE_EN
    req = armed_q & fire;
`else
    req = armed_q & fire & ~fire_q;
`endif
    // Counter reaches zero on this edge: shots are spaced exactly COOLDOWN frames apart.
    cd_ready = (cd_q <= CD_ONE);

    spawn_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!pl_q[i] && !found) begin
        spawn_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
    spawn = req & cd_ready & (PSY >= LASER_H_C) & found;

    for (int i = 0; i < 4; i++) begin
      pl_d[i] = pl_q[i];
      px_d[i] = px_q[i];
      py_d[i] = py_q[i];
      if (pl_q[i]) begin
        if (hit[i] || (py_q[i] < SPEED_C)) begin
          pl_d[i] = 1'b0;
          px_d[i] = '0;
          py_d[i] = '0;
        end else begin
          py_d[i] = py_q[i] - SPEED_C;
        end
      end else if (spawn && spawn_sel[i]) begin
        pl_d[i] = 1'b1;
        px_d[i] = PSX + X_OFF_C;
        py_d[i] = PSY - LASER_H_C;
      end
    end

    if (spawn) begin
      cd_d = CD_LOAD;
    end else if (cd_q != '0) begin
      cd_d = cd_q - CD_ONE;
    end else begin
      cd_d = cd_q;
    end
    shot_d = shot_q + {7'd0, spawn};
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pl_q    <= '0;
      cd_q    <= '0;
      fire_q  <= 1'b0;
      armed_q <= 1'b0;
      shot_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      pl_q    <= pl_d;
      cd_q    <= cd_d;
      fire_q  <= fire_d;
      armed_q <= armed_d;
      shot_q  <= shot_d;
      for (int i = 0; i < 4; i++) begin
        px_q[i] <= px_d[i];
        py_q[i] <= py_d[i];
      end
    end
  end

  assign PX1 = px_q[0];
  assign PX2 = px_q[1];
  assign PX3 = px_q[2];
  assign PX4 = px_q[3];
  assign PY1 = py_q[0];
  assign PY2 = py_q[1];
  assign PY3 = py_q[2];
  assign PY4 = py_q[3];
  assign PL1 = pl_q[0];
  assign PL2 = pl_q[1];
  assign PL3 = pl_q[2];
  assign PL4 = pl_q[3];

  assign laser_width  = LASER_W_C;
  assign laser_height = LASER_H_C;
  assign shot_count   = shot_q;

endmodule
`default_nettype wire

// File: tb/tb_player_laser.sv
`default_nettype none
// tb_player_laser : randomized and directed checks of player_laser against a frame-level model.
module tb_player_laser;

  localparam int SPEED    = 6;
  localparam int COOLDOWN = 8;
  localparam int LW       = 4;
  localparam int LH       = 12;
  localparam int SW       = 30;
  localparam int X_OFF    = (SW - LW) / 2;
`ifdef LASER_AUTOFIRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       Reset_n;
  logic       fire;
  logic [9:0] PSX, PSY;
  logic       h1, h2, h3, h4;
  logic [9:0] PX1, PX2, PX3, PX4, PY1, PY2, PY3, PY4;
  logic       PL1, PL2, PL3, PL4;
  logic [9:0] laser_width, laser_height;
  logic [7:0] shot_count;

  player_laser dut (
    .frame_clk   (clk),
    .Reset_n     (Reset_n),
    .fire        (fire),
    .PSX         (PSX),
    .PSY         (PSY),
    .h1          (h1),
    .h2          (h2),
    .h3          (h3),
    .h4          (h4),
    .PX1         (PX1),
    .PX2         (PX2),
    .PX3         (PX3),
    .PX4         (PX4),
    .PY1         (PY1),
    .PY2         (PY2),
    .PY3         (PY3),
    .PY4         (PY4),
    .PL1         (PL1),
    .PL2         (PL2),
    .PL3         (PL3),
    .PL4         (PL4),
    .laser_width (laser_width),
    .laser_height(laser_height),
    .shot_count  (shot_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [9:0] d_px [4];
  logic [9:0] d_py [4];
  logic       d_pl [4];
  always_comb begin
    d_px[0] = PX1; d_px[1] = PX2; d_px[2] = PX3; d_px[3] = PX4;
    d_py[0] = PY1; d_py[1] = PY2; d_py[2] = PY3; d_py[3] = PY4;
    d_pl[0] = PL1; d_pl[1] = PL2; d_pl[2] = PL3; d_pl[3] = PL4;
  end

  int errors = 0;
  int checks = 0;

  // Frame-level reference: lasers, frames since the last shot, previous fire level.
  bit         m_pl [4];
  logic [9:0] m_px [4];
  logic [9:0] m_py [4];
  int         m_since;
  bit         m_fire_prev;
  bit         m_armed;
  int         m_shots;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pl[i] = 1'b0; m_px[i] = '0; m_py[i] = '0;
    end
    m_since = 1000; m_fire_prev = 1'b0; m_armed = 1'b0; m_shots = 0;
  endtask

  task automatic model_step();
    bit       req;
    bit       was [4];
    int       k;
    bit [3:0] hv;
    hv  = {h4, h3, h2, h1};
    req = m_armed && fire && (AUTO || !m_fire_prev);
    for (int i = 0; i < 4; i++) was[i] = m_pl[i];
    for (int i = 0; i < 4; i++) begin
      if (was[i]) begin
        if (hv[i] || (int'(m_py[i]) < SPEED)) begin
          m_pl[i] = 1'b0; m_px[i] = '0; m_py[i] = '0;
        end else begin
          m_py[i] = 10'(int'(m_py[i]) - SPEED);
        end
      end
    end
    if (m_since < 1000) m_since++;
    k = -1;
    for (int i = 0; i < 4; i++) if (!was[i] && k < 0) k = i;
    if (req && m_since >= COOLDOWN && int'(PSY) >= LH && k >= 0) begin
      m_pl[k] = 1'b1;
      m_px[k] = 10'((int'(PSX) + X_OFF) % 1024);
      m_py[k] = 10'(int'(PSY) - LH);
      m_since = 0;
      m_shots = (m_shots + 1) % 256;
    end
    m_fire_prev = fire;
    m_armed     = 1'b1;
  endtask

  task automatic tick(input bit f);
    fire = f;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    fire = 1'b0; h1 = 0; h2 = 0; h3 = 0; h4 = 0;
    Reset_n = 1'b0;
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    model_reset();
    tick(1'b0);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; fire = 1'b1; PSX = 10'd100; PSY = 10'd400;
    h1 = 0; h2 = 0; h3 = 0; h4 = 0;
    @(posedge clk);
    #1;
    checks++;
    if ({PL1, PL2, PL3, PL4} !== 4'b0000) begin
      errors++; $display("FAIL reset_pl got=%b exp=0000", {PL1, PL2, PL3, PL4});
    end
    checks++;
    if ({PX1, PX2, PX3, PX4, PY1, PY2, PY3, PY4} !== 80'd0) begin
      errors++; $display("FAIL reset_pos PX1=%0d PY1=%0d exp=0", PX1, PY1);
    end
    checks++;
    if (shot_count !== 8'd0) begin
      errors++; $display("FAIL reset_shots got=%0d exp=0", shot_count);
    end
    checks++;
    if (laser_width !== 10'(LW) || laser_height !== 10'(LH)) begin
      errors++; $display("FAIL laser_size got=%0dx%0d exp=%0dx%0d", laser_width, laser_height, LW, LH);
    end
  endtask

  task automatic test_single_shot();
    apply_reset();
    PSX = 10'd100; PSY = 10'd400;
    tick(1'b1);
    checks++;
    if (PL1 !== 1'b1 || PX1 !== 10'd113 || PY1 !== 10'd388 || shot_count !== 8'd1) begin
      errors++; $display("FAIL single_spawn PL1=%b PX1=%0d PY1=%0d shots=%0d exp 1/113/388/1",
                         PL1, PX1, PY1, shot_count);
    end
    tick(1'b0);
    checks++;
    if (PY1 !== 10'd382) begin
      errors++; $display("FAIL single_move PY1=%0d exp=382", PY1);
    end
  endtask

  task automatic test_fill_slots();
    apply_reset();
    PSX = 10'd200; PSY = 10'd400;
    for (int n = 0; n < 4; n++) begin
      tick(1'b1);
      repeat (8) tick(1'b0);
    end
    tick(1'b1);
    checks++;
    if ({PL1, PL2, PL3, PL4} !== 4'b1111 || shot_count !== 8'd4) begin
      errors++; $display("FAIL fill_full pl=%b shots=%0d exp=1111/4", {PL1, PL2, PL3, PL4}, shot_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d_px[i] !== m_px[i] || d_py[i] !== m_py[i]) begin
        errors++; $display("FAIL fill_pos slot%0d got=%0d,%0d exp=%0d,%0d",
                           i + 1, d_px[i], d_py[i], m_px[i], m_py[i]);
      end
    end
  endtask

  task automatic test_hit();
    apply_reset();
    PSX = 10'd50; PSY = 10'd300;
    tick(1'b1);
    repeat (8) tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    h2 = 1'b1; h3 = 1'b1;
    tick(1'b0);
    h2 = 1'b0; h3 = 1'b0;
    checks++;
    if (PL2 !== 1'b0 || PX2 !== 10'd0 || PY2 !== 10'd0) begin
      errors++; $display("FAIL hit_clear PL2=%b PX2=%0d PY2=%0d exp 0/0/0", PL2, PX2, PY2);
    end
    checks++;
    if (PL1 !== 1'b1 || PY1 !== m_py[0] || PL3 !== 1'b0 || PL4 !== 1'b0) begin
      errors++; $display("FAIL hit_others PL1=%b PY1=%0d PL3=%b PL4=%b exp 1/%0d/0/0",
                         PL1, PY1, PL3, PL4, m_py[0]);
    end
  endtask

  task automatic test_top_exit();
    apply_reset();
    PSX = 10'd10; PSY = 10'd233;
    tick(1'b1);
    PSY = 10'd400;
    for (int n = 0; n < 3; n++) begin
      repeat (8) tick(1'b0);
      tick(1'b1);
    end
    repeat (9) tick(1'b0);
    checks++;
    if (PL1 !== 1'b1 || PY1 !== 10'd5) begin
      errors++; $display("FAIL exit_pre PL1=%b PY1=%0d exp 1/5", PL1, PY1);
    end
    tick(1'b1);
    checks++;
    if (PL1 !== 1'b0 || PX1 !== 10'd0 || shot_count !== 8'd4) begin
      errors++; $display("FAIL exit_clear PL1=%b PX1=%0d shots=%0d exp 0/0/4", PL1, PX1, shot_count);
    end
    tick(1'b0);
    tick(1'b1);
    checks++;
    if (PL1 !== 1'b1 || PY1 !== 10'd388 || shot_count !== 8'd5) begin
      errors++; $display("FAIL exit_respawn PL1=%b PY1=%0d shots=%0d exp 1/388/5", PL1, PY1, shot_count);
    end
  endtask

  task automatic test_cooldown();
    apply_reset();
    PSX = 10'd300; PSY = 10'd450;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    checks++;
    if (shot_count !== 8'd1 || PL2 !== 1'b0) begin
      errors++; $display("FAIL cooldown_drop shots=%0d PL2=%b exp 1/0", shot_count, PL2);
    end
    repeat (4) tick(1'b0);
    tick(1'b1);
    checks++;
    if (shot_count !== 8'd2 || PL2 !== 1'b1) begin
      errors++; $display("FAIL cooldown_expire shots=%0d PL2=%b exp 2/1", shot_count, PL2);
    end
  endtask

  task automatic test_autofire();
    int exp_shots;
    apply_reset();
    PSX = 10'd400; PSY = 10'd470;
    repeat (20) tick(1'b1);
    exp_shots = AUTO ? 3 : 1;
    checks++;
    if (int'(shot_count) != exp_shots || shot_count !== 8'(m_shots)) begin
      errors++; $display("FAIL autofire shots=%0d exp=%0d", shot_count, exp_shots);
    end
    fire = 1'b0;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    PSX = 10'd60; PSY = 10'd350;
    tick(1'b1);
    repeat (3) tick(1'b0);
    @(posedge clk);
    #3;
    Reset_n = 1'b0;
    fire    = 1'b1;
    #1;
    checks++;
    if (PL1 !== 1'b0 || PY1 !== 10'd0 || shot_count !== 8'd0) begin
      errors++; $display("FAIL async_reset PL1=%b PY1=%0d shots=%0d exp 0/0/0", PL1, PY1, shot_count);
    end
    model_reset();
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    tick(1'b1);
    checks++;
    if (PL1 !== 1'b0 || shot_count !== 8'd0) begin
      errors++; $display("FAIL held_fire PL1=%b shots=%0d exp 0/0", PL1, shot_count);
    end
    tick(1'b0);
    tick(1'b1);
    checks++;
    if (PL1 !== 1'b1 || PY1 !== 10'd338 || shot_count !== 8'd1) begin
      errors++; $display("FAIL post_reset_spawn PL1=%b PY1=%0d shots=%0d exp 1/338/1", PL1, PY1, shot_count);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 149) == 0) apply_reset();
      if ($urandom_range(0, 7) == 0) PSX = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) PSY = 10'($urandom_range(0, 479));
      h1 = ($urandom_range(0, 9) == 0);
      h2 = ($urandom_range(0, 9) == 0);
      h3 = ($urandom_range(0, 9) == 0);
      h4 = ($urandom_range(0, 9) == 0);
      tick(1'($urandom_range(0, 2) == 0));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (d_pl[i] !== m_pl[i] || d_px[i] !== m_px[i] || d_py[i] !== m_py[i]) begin
          errors++; $display("FAIL rand_slot%0d cyc=%0d got pl=%b x=%0d y=%0d exp pl=%b x=%0d y=%0d",
                             i + 1, cyc, d_pl[i], d_px[i], d_py[i], m_pl[i], m_px[i], m_py[i]);
        end
      end
      checks++;
      if (shot_count !== 8'(m_shots)) begin
        errors++; $display("FAIL rand_shots cyc=%0d got=%0d exp=%0d", cyc, shot_count, m_shots);
      end
    end
    h1 = 0; h2 = 0; h3 = 0; h4 = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_shot();
    test_fill_slots();
    test_hit();
    test_top_exit();
    test_cooldown();
    test_autofire();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
